// File: rtl/avalon_len_enforcer_pkg.sv
// Shared types and constants for the Avalon-ST length enforcer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package avalon_len_enforcer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IN_MSG = 2'd1,
    DROP   = 2'd2
  } len_sm_t;

  localparam int STATS_W = 32;

  // Width of the empty field; a one-byte bus still carries a 1-bit field.
  function automatic int empty_w(input int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST stream bundle: valid/rdy handshake with sop, eop, data, empty.
// Latency: n/a (wires only).
// Backpressure: a word transfers when valid and rdy are both high.
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 16
);
  localparam int EMPTY_W = avalon_len_enforcer_pkg::empty_w(DATA_WIDTH_IN_BYTES);

  logic                             valid;
  logic                             rdy;
  logic                             sop;
  logic                             eop;
  logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
  logic [EMPTY_W-1:0]               empty;

  modport master (output valid, sop, eop, data, empty, input rdy);
  modport slave  (input valid, sop, eop, data, empty, output rdy);
endinterface

// File: rtl/avalon_length_enforcer_pipe.sv
// One-entry registered valid/rdy stage carrying an opaque payload.
// Latency: one cycle; full throughput when downstream is ready.
// Backpressure: accepts when empty or when the held word is being taken.
module avalon_pipe_reg #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld_i,
  output logic                 in_rdy_o,
  input  logic [PAYLOAD_W-1:0] in_dat_i,
  output logic                 out_vld_o,
  input  logic                 out_rdy_i,
  output logic [PAYLOAD_W-1:0] out_dat_o
);
  logic                 vld_q, vld_d;
  logic [PAYLOAD_W-1:0] dat_q, dat_d;

  assign in_rdy_o  = !vld_q | out_rdy_i;
  assign out_vld_o = vld_q;
  assign out_dat_o = dat_q;

  // Load on an accepted word, otherwise empty out once downstream takes it.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (in_vld_i && in_rdy_o) begin
      vld_d = 1'b1;
      dat_d = in_dat_i;
    end else if (out_rdy_i) begin
      vld_d = 1'b0;
    end
  end

  // Holding register, cleared on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end
endmodule

// File: rtl/avalon_length_enforcer.sv
// Enforces a maximum message length; over-long messages end early with eop, remainder drained.
// Latency: one cycle from accepted input word to out_msg.valid, one word per cycle.
// Backpressure: input follows the output stage, except while draining where input is always taken.
// Optional statistics counters (msg_cnt, trunc_cnt) with LEN_ENFORCER_STATS_EN.
module avalon_length_enforcer
  import avalon_len_enforcer_pkg::*;
#(
  parameter int DATA_WIDTH_IN_BYTES = 16,
  parameter int MAX_MSG_WORDS       = 64
) (
  input  logic        clk,
  input  logic        rst,
  avalon_st_if.slave  in_msg,
  avalon_st_if.master out_msg,
  output logic        truncated_indi
`ifdef LEN_ENFORCER_STATS_EN
  ,
  output logic [STATS_W-1:0] msg_cnt,
  output logic [STATS_W-1:0] trunc_cnt
`endif
);
  localparam int DW = 8 * DATA_WIDTH_IN_BYTES;
  localparam int EW = empty_w(DATA_WIDTH_IN_BYTES);
  localparam int CW = $clog2(MAX_MSG_WORDS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_MSG_WORDS);

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
    logic [DW-1:0] data;
  } beat_t;

  len_sm_t       state_q, state_d;
  logic [CW-1:0] word_cnt_q, word_cnt_d, cnt_inc;
  logic          accept, fwd, trunc_hit, trunc_q;
  logic          in_rdy, pipe_in_rdy, pipe_out_vld;
  beat_t         in_beat, out_beat;

  assign accept  = in_msg.valid & in_rdy;
  assign cnt_inc = word_cnt_q + CW'(1);

  // State, word count and truncation pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      trunc_q    <= accept & trunc_hit;
    end
  end

  // Next state and word count; only an accepted word moves the machine.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (in_msg.sop && !in_msg.eop) begin
            state_d    = IN_MSG;
            word_cnt_d = CW'(1);
          end
        end
        IN_MSG: begin
          if (in_msg.eop) begin
            state_d    = IDLE;
            word_cnt_d = '0;
          end else begin
            word_cnt_d = cnt_inc;
            if (cnt_inc == MAX_CNT) state_d = DROP;
          end
        end
        DROP: begin
          if (in_msg.eop) begin
            state_d    = IDLE;
            word_cnt_d = '0;
          end
        end
        default: begin
          state_d    = IDLE;
          word_cnt_d = '0;
        end
      endcase
    end
  end

  // Per-state forwarding decision and the rewritten sop/eop/empty of the word.
  always_comb begin
    fwd          = 1'b0;
    trunc_hit    = 1'b0;
    in_rdy       = pipe_in_rdy;
    in_beat      = '0;
    in_beat.data = in_msg.data;
    case (state_q)
      IDLE: begin
        // Words without sop between messages are swallowed.
        if (in_msg.sop) begin
          fwd         = 1'b1;
          in_beat.sop = 1'b1;
          in_beat.eop = in_msg.eop;
          if (in_msg.eop) in_beat.empty = in_msg.empty;
        end
      end
      IN_MSG: begin
        fwd = 1'b1;
        if (in_msg.eop) begin
          in_beat.eop   = 1'b1;
          in_beat.empty = in_msg.empty;
        end else if (cnt_inc == MAX_CNT) begin
          // Forced end: the word is full, so empty stays 0.
          in_beat.eop = 1'b1;
          trunc_hit   = 1'b1;
        end
      end
      DROP: begin
        in_rdy = 1'b1;
      end
      default: begin
        in_rdy = 1'b1;
      end
    endcase
  end

  assign in_msg.rdy     = in_rdy;
  assign truncated_indi = trunc_q;

  avalon_pipe_reg #(
    .PAYLOAD_W ($bits(beat_t))
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_vld_i  (in_msg.valid & fwd),
    .in_rdy_o  (pipe_in_rdy),
    .in_dat_i  (in_beat),
    .out_vld_o (pipe_out_vld),
    .out_rdy_i (out_msg.rdy),
    .out_dat_o (out_beat)
  );

  assign out_msg.valid = pipe_out_vld;
  assign out_msg.sop   = out_beat.sop;
  assign out_msg.eop   = out_beat.eop;
  assign out_msg.empty = out_beat.empty;
  assign out_msg.data  = out_beat.data;

`ifdef LEN_ENFORCER_STATS_EN
  logic [STATS_W-1:0] msg_cnt_q, trunc_cnt_q;

  // Count messages leaving on out_msg and truncation events; both wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msg_cnt_q   <= '0;
      trunc_cnt_q <= '0;
    end else begin
      if (pipe_out_vld && out_msg.rdy && out_beat.eop) msg_cnt_q <= msg_cnt_q + STATS_W'(1);
      if (trunc_q) trunc_cnt_q <= trunc_cnt_q + STATS_W'(1);
    end
  end

  assign msg_cnt   = msg_cnt_q;
  assign trunc_cnt = trunc_cnt_q;
`endif

endmodule

// File: tb/tb_avalon_length_enforcer.sv
// Bench for avalon_length_enforcer with MAX_MSG_WORDS=4 and an 8-byte bus.
// Directed word table, reset-mid-message sequence, then randomized traffic vs a message-level model.
// Output rdy is randomized during the random phase.
`timescale 1ns/1ps
module tb_avalon_length_enforcer;
  localparam int DWB  = 8;
  localparam int MAXW = 4;
  localparam int DW   = 64;
  localparam int EW   = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(DWB)) in_if ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(DWB)) out_if ();
  logic truncated_indi;
`ifdef LEN_ENFORCER_STATS_EN
  logic [31:0] msg_cnt, trunc_cnt;
`endif

  avalon_length_enforcer #(
    .DATA_WIDTH_IN_BYTES (DWB),
    .MAX_MSG_WORDS       (MAXW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_msg         (in_if),
    .out_msg        (out_if),
    .truncated_indi (truncated_indi)
`ifdef LEN_ENFORCER_STATS_EN
    ,
    .msg_cnt        (msg_cnt),
    .trunc_cnt      (trunc_cnt)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Output rdy: constant 1 unless randomization is enabled.
  logic tb_out_rdy = 1'b1;
  bit   rnd_rdy    = 1'b0;
  assign out_if.rdy = tb_out_rdy;
  always @(posedge clk) begin
    #1;
    tb_out_rdy = rnd_rdy ? ($urandom % 3 != 0) : 1'b1;
  end

  // Directed vectors: one input word per cycle, expected output seen one cycle later.
  typedef struct {
    logic sop, eop; logic [EW-1:0] emp;
    logic e_vld, e_sop, e_eop; logic [EW-1:0] e_emp; logic e_trunc;
  } vec_t;
  vec_t vt[$];

  function automatic void addv(input logic s, e, input logic [EW-1:0] m,
                               input logic ev, es, ee, input logic [EW-1:0] em, input logic et);
    vec_t v;
    v.sop = s; v.eop = e; v.emp = m;
    v.e_vld = ev; v.e_sop = es; v.e_eop = ee; v.e_emp = em; v.e_trunc = et;
    vt.push_back(v);
  endfunction

  // Message-level expectations for the random phase.
  typedef struct packed {
    logic sop; logic eop; logic [EW-1:0] emp; logic [DW-1:0] dat;
  } beat_t;
  beat_t exp_q[$];
  beat_t mon_b;
  bit    mon_en     = 1'b0;
  int    seen_trunc = 0;
  int    exp_trunc  = 0;
  int    exp_msgs   = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (truncated_indi) begin
        seen_trunc++;
        chk("trunc_align", 128'({out_if.valid, out_if.eop}), 128'(2'b11));
      end
      if (out_if.valid && out_if.rdy) begin
        if (exp_q.size() == 0) chk("unexpected_word", 128'(1), 128'(0));
        else begin
          mon_b = exp_q.pop_front();
          chk("rand_word", 128'({out_if.sop, out_if.eop, out_if.empty, out_if.data}), 128'(mon_b));
        end
      end
    end
  end

  // Drives one word (caller is at posedge+1) and returns at posedge+1 after acceptance.
  task automatic send_word(input logic s, e, input logic [EW-1:0] m, input logic [DW-1:0] d,
                           input bit must_not_stall);
    int waitc = 0;
    in_if.valid = 1'b1; in_if.sop = s; in_if.eop = e; in_if.empty = m; in_if.data = d;
    @(negedge clk);
    if (must_not_stall) chk("drop_rdy", 128'(in_if.rdy), 128'(1));
    while (!in_if.rdy && waitc < 1000) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_if.rdy) chk("accept_timeout", 128'(0), 128'(1));
    @(posedge clk); #1;
    in_if.valid = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] d;
    int len, c;
    in_if.valid = 1'b0; in_if.sop = 1'b0; in_if.eop = 1'b0; in_if.empty = '0; in_if.data = '0;

    // MSG A: 3 words
    addv(1,0,0, 1,1,0,0,0); addv(0,0,2, 1,0,0,0,0); addv(0,1,3, 1,0,1,3,0);
    // MSG B: 7 words, empty 5 on last, stray sop mid-message and in drain
    addv(1,0,1, 1,1,0,0,0); addv(0,0,0, 1,0,0,0,0); addv(1,0,0, 1,0,0,0,0);
    addv(0,0,4, 1,0,1,0,1); addv(0,0,0, 0,0,0,0,0); addv(1,0,0, 0,0,0,0,0);
    addv(0,1,5, 0,0,0,0,0);
    // MSG C: 2 words, accepted normally after the drain
    addv(1,0,0, 1,1,0,0,0); addv(0,1,2, 1,0,1,2,0);
    // MSG D: exactly MAX words
    addv(1,0,0, 1,1,0,0,0); addv(0,0,0, 1,0,0,0,0); addv(0,0,0, 1,0,0,0,0);
    addv(0,1,6, 1,0,1,6,0);
    // words without sop between messages
    addv(0,0,7, 0,0,0,0,0); addv(0,1,1, 0,0,0,0,0);
    // back-to-back single-word messages
    addv(1,1,4, 1,1,1,4,0); addv(1,1,0, 1,1,1,0,0);
    // MAX+1 words ending with eop: truncated, eop word drained
    addv(1,0,0, 1,1,0,0,0); addv(0,0,0, 1,0,0,0,0); addv(0,0,0, 1,0,0,0,0);
    addv(0,0,0, 1,0,1,0,1); addv(0,1,3, 0,0,0,0,0);
    addv(1,1,2, 1,1,1,2,0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", 128'({out_if.valid, out_if.sop, out_if.eop, out_if.empty, out_if.data}), 128'(0));
    chk("rst_trunc", 128'(truncated_indi), 128'(0));
    chk("rst_in_rdy", 128'(in_if.rdy), 128'(1));
`ifdef LEN_ENFORCER_STATS_EN
    chk("rst_stats", 128'({msg_cnt, trunc_cnt}), 128'(0));
`endif
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < vt.size(); i++) begin
      d = 64'hA5A5_0000_0000_0000 | 64'(i);
      in_if.valid = 1'b1; in_if.sop = vt[i].sop; in_if.eop = vt[i].eop;
      in_if.empty = vt[i].emp; in_if.data = d;
      @(posedge clk); #1;
      if (vt[i].e_vld) begin
        chk($sformatf("vec%0d_ctl", i),
            128'({out_if.valid, out_if.sop, out_if.eop, out_if.empty, truncated_indi}),
            128'({1'b1, vt[i].e_sop, vt[i].e_eop, vt[i].e_emp, vt[i].e_trunc}));
        chk($sformatf("vec%0d_data", i), 128'(out_if.data), 128'(d));
      end else begin
        chk($sformatf("vec%0d_idle", i), 128'({out_if.valid, truncated_indi}), 128'(0));
      end
    end
    in_if.valid = 1'b0;
    @(posedge clk); #1;

    // Reset during word 2 of a message
    in_if.valid = 1'b1; in_if.sop = 1'b1; in_if.eop = 1'b0; in_if.empty = 3'd0;
    in_if.data = 64'h1111;
    @(posedge clk); #1;
    chk("pre_rst_w1", 128'({out_if.valid, out_if.sop, out_if.data}), 128'({2'b11, 64'h1111}));
    in_if.sop = 1'b0; in_if.data = 64'h2222;
    #2 rst = 1'b0;
    #1;
    chk("midrst_clear",
        128'({out_if.valid, out_if.sop, out_if.eop, out_if.empty, out_if.data, truncated_indi}),
        128'(0));
    in_if.valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    exp_msgs = 0;
    // Exactly-MAX message after reset: a stale word count would truncate it early.
    for (int w = 0; w < MAXW; w++) begin
      in_if.valid = 1'b1; in_if.sop = (w == 0); in_if.eop = (w == MAXW - 1);
      in_if.empty = (w == MAXW - 1) ? 3'd2 : 3'd5; in_if.data = 64'h3000 + 64'(w);
      @(posedge clk); #1;
      chk($sformatf("postrst_w%0d", w),
          128'({out_if.valid, out_if.sop, out_if.eop, out_if.empty, truncated_indi, out_if.data}),
          128'({1'b1, w == 0, w == MAXW - 1, (w == MAXW - 1) ? 3'd2 : 3'd0, 1'b0,
                64'h3000 + 64'(w)}));
    end
    in_if.valid = 1'b0;
    exp_msgs = 1;
    @(posedge clk); #1;

    // Randomized traffic with random downstream stalls
    mon_en  = 1'b1;
    rnd_rdy = 1'b1;
    for (int m = 0; m < 100; m++) begin
      len = $urandom_range(1, 10);
      exp_msgs++;
      for (int w = 0; w < len; w++) begin
        logic s, e; logic [EW-1:0] em; beat_t b;
        s  = (w == 0) ? 1'b1 : ($urandom % 8 == 0);
        e  = (w == len - 1);
        em = EW'($urandom);
        d  = {$urandom, $urandom};
        if (len <= MAXW) begin
          b = '{sop: (w == 0), eop: e, emp: (e ? em : 3'd0), dat: d};
          exp_q.push_back(b);
        end else if (w < MAXW) begin
          b = '{sop: (w == 0), eop: (w == MAXW - 1), emp: 3'd0, dat: d};
          exp_q.push_back(b);
          if (w == MAXW - 1) exp_trunc++;
        end
        send_word(s, e, em, d, (len > MAXW) && (w >= MAXW));
        if ($urandom % 4 == 0) begin
          @(posedge clk); #1;
        end
      end
    end
    c = 0;
    while (exp_q.size() != 0 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("drain_complete", 128'(exp_q.size()), 128'(0));
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;
    chk("trunc_pulses", 128'(seen_trunc), 128'(exp_trunc));
`ifdef LEN_ENFORCER_STATS_EN
    chk("msg_cnt", 128'(msg_cnt), 128'(exp_msgs));
    chk("trunc_cnt", 128'(trunc_cnt), 128'(exp_trunc));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/avalon_length_enforcer.md
# avalon_length_enforcer

Downstream stage of the sop/eop enforcer: takes its well-framed Avalon-ST messages and enforces a maximum message length in words. Over-long messages are truncated: the last allowed word is forced to end-of-packet with full data, and the remainder is drained and discarded. Output is registered, with one cycle of latency at full throughput.

## Interface
- DATA_WIDTH_IN_BYTES, 16, data bus width in bytes; empty width is $clog2(DATA_WIDTH_IN_BYTES).
- MAX_MSG_WORDS, 64, maximum accepted words per message; must be ≥ 2.
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- in_msg  avalon_st_if.slave  —  input stream (valid, rdy, sop, eop, data, empty).
- out_msg  avalon_st_if.master  —  output stream, same signal set.
- truncated_indi  output  1  one-cycle pulse when a truncation occurs.
- msg_cnt  output  32  messages emitted; present only with LEN_ENFORCER_STATS_EN.
- trunc_cnt  output  32  messages truncated; present only with LEN_ENFORCER_STATS_EN.

## Operation
- States: IDLE (between messages), IN_MSG, DROP. An input word is accepted when in_msg.valid & in_msg.rdy.
- word_cnt has width $clog2(MAX_MSG_WORDS+1). It counts words accepted in the current message.

Transitions and per-state behaviour:
- **IDLE, sop & eop accepted:** single-word message. Forwarded unchanged; stay in IDLE.
- **IDLE, sop & !eop accepted:** forward the word, set word_cnt=1, go to IN_MSG.
- **IDLE, word without sop:** accepted and discarded (defensive); no indication.
- **IN_MSG, each accepted word:** word_cnt+1.
  - If eop: forward unchanged and go to IDLE.
  - Else if new word_cnt == MAX_MSG_WORDS: forward with eop=1 and empty=0, pulse truncated_indi, go to DROP.
  - Else: forward with eop=0.
- **IN_MSG, sop asserted:** ignored and treated as data. out sop is driven 0 on all non-first words.
- **DROP:** in_msg.rdy=1 regardless of downstream. Every word is discarded. An accepted eop returns the block to IDLE. A message of exactly MAX_MSG_WORDS whose last word carries eop is not truncated; that word takes the IN_MSG eop path.
- **empty:** forwarded only on words emitted with their original eop. Driven 0 on all other words.
- **data:** forwarded unmodified.

## Timing
- Latency: one cycle, from accepted input word to out_msg.valid.
- Output register is a one-entry pipeline stage:
  - in_msg.rdy = !out_valid_q | out_msg.rdy (outside DROP), so back-to-back transfers run at one word per cycle.
  - out_msg.valid holds and data/sop/eop/empty are stable while out_msg.rdy=0.
- truncated_indi is asserted in the cycle the truncating word is accepted (registered output, visible the next cycle, aligned with out_msg.valid of that word).
- Reset values:
  - out_msg.valid/sop/eop/empty/data = 0.
  - truncated_indi = 0; state = IDLE; word_cnt = 0; msg_cnt = trunc_cnt = 0.
- Reset mid-message: the output register is cleared and the partial message is lost. The block resumes in IDLE, awaiting sop.
- Simultaneous truncation and downstream stall: the state advances only on acceptance, so no word is lost or duplicated.

## Configuration
- LEN_ENFORCER_STATS_EN defined:
  - msg_cnt increments on each eop transferred on out_msg.
  - trunc_cnt increments on each truncated_indi pulse.
  - Both wrap modulo 2^32 and are reset to 0.
- Not defined: both ports and their counters are absent. Behaviour is otherwise identical.

## Structure
- avalon_len_enforcer_pkg holds:
  - typedef enum len_sm_t {IDLE, IN_MSG, DROP};
  - localparam STATS_W = 32.
- Sub-module avalon_pipe_reg holds the one-entry registered valid/rdy stage (payload = sop, eop, empty, data). It is instantiated once, behind the state/counter logic.

## Test plan
- MAX_MSG_WORDS=4, 3-word message, out_msg.rdy=1: 3 output words, sop on word 1, eop on word 3, empty passed, truncated_indi never set.
- MAX_MSG_WORDS=4, 7-word message with empty=5 on the last word: 4 words out, word 4 has eop=1 and empty=0, one truncated_indi pulse, words 5–7 consumed with no output, next message accepted normally.
- Exactly 4-word message (MAX=4): 4 words out with the original eop/empty; no truncation; state IDLE after.
- Single-word sop&eop message followed immediately by another: two 1-word outputs on consecutive cycles.
- Random out_msg.rdy toggling on 100 messages of length 1–10, MAX=4: output matches the reference model word-for-word; no drops or duplicates; DROP-phase input never stalls.
- Reset asserted during word 2 of a message: all outputs are 0 next cycle; after release, a new sop message passes intact. With LEN_ENFORCER_STATS_EN, msg_cnt/trunc_cnt equal the expected totals after the random run.
